// File: rtl/crc_frame_ctrl.sv
// Frame controller around a serial 8-bit CRC engine: serializes bytes LSB-first
// onto Data/Active, then gathers the engine's 8 serial CRC bits into Crc_Byte.
module crc_frame_ctrl #(
  parameter int unsigned WAIT_MAX = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] In_Byte,
  input  logic       In_Valid,
  input  logic       In_Last,
  output logic       In_Ready,
  output logic       Data,
  output logic       Active,
  input  logic       Crc_Bit,
  input  logic       Crc_Valid,
  output logic [7:0] Crc_Byte,
  output logic       Crc_Done,
  output logic       Crc_Err,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CRC, COLLECT} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

  state_t     state, state_nxt;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic       last_q;
  logic       underrun;
  logic [3:0] wait_cnt;
  logic [2:0] col_cnt;
  logic [7:0] col_sr;

  logic load, fin, timeout, col_ok, col_err;

  assign In_Ready = (state == IDLE) || (state == SHIFT && bit_cnt == 3'd7 && !last_q);
  assign Busy     = (state != IDLE);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    fin       = 1'b0;
    timeout   = 1'b0;
    col_ok    = 1'b0;
    col_err   = 1'b0;
    case (state)
      IDLE: if (In_Valid) begin
        load      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: if (bit_cnt == 3'd7) begin
        // A byte waiting at bit 7 keeps the frame gapless; otherwise the frame ends here.
        if (!last_q && In_Valid) load = 1'b1;
        else begin
          fin       = 1'b1;
          state_nxt = WAIT_CRC;
        end
      end
      WAIT_CRC: begin
        if (Crc_Valid) state_nxt = COLLECT;
        else if (wait_cnt == WAIT_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      COLLECT: begin
        if (!Crc_Valid) begin
          col_err   = 1'b1;
          state_nxt = IDLE;
        end else if (col_cnt == 3'd7) begin
          col_ok    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sr       <= '0;
      bit_cnt  <= '0;
      last_q   <= 1'b0;
      underrun <= 1'b0;
      wait_cnt <= '0;
      col_cnt  <= '0;
      col_sr   <= '0;
      Data     <= 1'b0;
      Active   <= 1'b0;
      Crc_Byte <= '0;
      Crc_Done <= 1'b0;
      Crc_Err  <= 1'b0;
    end else begin
      Crc_Done <= 1'b0;
      if (load) begin
        sr      <= In_Byte;
        last_q  <= In_Last;
        bit_cnt <= '0;
        Data    <= In_Byte[0];
        Active  <= 1'b1;
      end else if (state == SHIFT && !fin) begin
        Data    <= sr[bit_cnt + 3'd1];
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (fin) begin
        Active   <= 1'b0;
        Data     <= 1'b0;
        underrun <= !last_q;
        wait_cnt <= '0;
      end
      if (state == WAIT_CRC) begin
        if (Crc_Valid) begin
          col_sr  <= {7'b0, Crc_Bit};
          col_cnt <= 3'd1;
        end else begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end
      if (state == COLLECT && Crc_Valid) begin
        col_sr[col_cnt] <= Crc_Bit;
        col_cnt         <= col_cnt + 3'd1;
      end
      if (col_ok) begin
        Crc_Byte <= {Crc_Bit, col_sr[6:0]};
        Crc_Err  <= underrun;
        Crc_Done <= 1'b1;
        underrun <= 1'b0;
      end
      // Failed collections also clear underrun so it cannot leak into the next frame.
      if (timeout || col_err) begin
        Crc_Byte <= '0;
        Crc_Err  <= 1'b1;
        Crc_Done <= 1'b1;
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Scoreboard bench for crc_frame_ctrl: expected serial bits, Active run lengths
// and CRC results are queued by the driver and popped by a negedge monitor.
module tb_crc_frame_ctrl;

  localparam int WAIT_MAX = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] In_Byte;
  logic       In_Valid;
  logic       In_Last;
  logic       In_Ready;
  logic       Data;
  logic       Active;
  logic       Crc_Bit;
  logic       Crc_Valid;
  logic [7:0] Crc_Byte;
  logic       Crc_Done;
  logic       Crc_Err;
  logic       Busy;

  crc_frame_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .Clk(Clk), .Rst(Rst),
    .In_Byte(In_Byte), .In_Valid(In_Valid), .In_Last(In_Last), .In_Ready(In_Ready),
    .Data(Data), .Active(Active),
    .Crc_Bit(Crc_Bit), .Crc_Valid(Crc_Valid),
    .Crc_Byte(Crc_Byte), .Crc_Done(Crc_Done), .Crc_Err(Crc_Err), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int run = 0;

  logic       bitq[$];
  int         runq[$];
  logic [8:0] resq[$];   // {err, byte}

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (Rst) run = 0;
    else begin
      if (Active) begin
        run++;
        if (bitq.size() == 0) chk("data_extra", 32'(1), 32'(0));
        else                  chk("data", 32'(Data), 32'(bitq.pop_front()));
      end else begin
        chk("data_idle", 32'(Data), 32'(0));
        if (run > 0) begin
          if (runq.size() == 0) chk("active_run_unexp", 32'(run), 32'(0));
          else                  chk("active_len", 32'(run), 32'(runq.pop_front()));
          run = 0;
        end
      end
      if (Crc_Done) begin
        logic [8:0] r;
        done_cnt++;
        if (resq.size() == 0) chk("done_unexp", 32'(1), 32'(0));
        else begin
          r = resq.pop_front();
          chk("crc_byte", 32'(Crc_Byte), 32'(r[7:0]));
          chk("crc_err",  32'(Crc_Err),  32'(r[8]));
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input logic last, output int waited);
    In_Byte = b; In_Valid = 1'b1; In_Last = last; waited = 0;
    while (!In_Ready && waited < 30) begin tick(); waited++; end
    if (!In_Ready) chk("accept_timeout", 32'(0), 32'(1));
    for (int i = 0; i < 8; i++) bitq.push_back(b[i]);
    tick();
    In_Valid = 1'b0; In_Last = 1'b0;
  endtask

  task automatic wait_fall();
    int n = 0;
    while (Active && n < 50) begin tick(); n++; end
    if (Active) chk("fall_timeout", 32'(1), 32'(0));
  endtask

  // Engine model: starts returning bits two cycles after Active falls.
  task automatic engine(input logic [7:0] val, input int nbits);
    tick();
    for (int i = 0; i < nbits; i++) begin
      Crc_Valid = 1'b1; Crc_Bit = val[i];
      tick();
    end
    Crc_Valid = 1'b0; Crc_Bit = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 50) begin tick(); n++; end
    chk("done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic frame_a5(input int target);
    int w;
    runq.push_back(8);
    resq.push_back({1'b0, 8'h3C});
    push_byte(8'hA5, 1'b1, w);
    wait_fall();
    engine(8'h3C, 8);
    wait_done(target);
    chk("busy_after", 32'(Busy), 32'(0));
  endtask

  initial begin
    int w, n, snap;
    Rst = 1'b1; In_Byte = '0; In_Valid = 1'b0; In_Last = 1'b0;
    Crc_Bit = 1'b0; Crc_Valid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_data",     32'(Data),     32'(0));
    chk("rst_active",   32'(Active),   32'(0));
    chk("rst_crc_byte", 32'(Crc_Byte), 32'(0));
    chk("rst_done",     32'(Crc_Done), 32'(0));
    chk("rst_err",      32'(Crc_Err),  32'(0));
    chk("rst_busy",     32'(Busy),     32'(0));
    chk("rst_ready",    32'(In_Ready), 32'(1));
    Rst = 1'b0;
    tick();

    // single byte, good CRC
    frame_a5(1);
    repeat (3) tick();
    chk("crc_hold", 32'(Crc_Byte), 32'(8'h3C));

    // gapless two-byte frame
    runq.push_back(16);
    resq.push_back({1'b0, 8'hC3});
    push_byte(8'h01, 1'b0, w);
    push_byte(8'h80, 1'b1, w);
    chk("ready_bit7_wait", 32'(w), 32'(7));
    chk("ready_low_after", 32'(In_Ready), 32'(0));
    wait_fall();
    engine(8'hC3, 8);
    wait_done(2);

    // underrun: no second byte at bit 7
    runq.push_back(8);
    resq.push_back({1'b1, 8'h5A});
    push_byte(8'hFF, 1'b0, w);
    wait_fall();
    engine(8'h5A, 8);
    wait_done(3);

    // timeout: engine silent
    runq.push_back(8);
    resq.push_back({1'b1, 8'h00});
    push_byte(8'h3E, 1'b1, w);
    wait_fall();
    n = 0;
    while (!Crc_Done && n < 20) begin tick(); n++; end
    chk("timeout_cycles", 32'(n), 32'(WAIT_MAX));
    chk("timeout_busy", 32'(Busy), 32'(0));
    wait_done(4);

    // Crc_Valid drops after 5 bits
    runq.push_back(8);
    resq.push_back({1'b1, 8'h00});
    push_byte(8'h77, 1'b1, w);
    wait_fall();
    engine(8'hFF, 5);
    wait_done(5);

    // reset at bit 3 of the second byte
    push_byte(8'h11, 1'b0, w);
    push_byte(8'h22, 1'b1, w);
    repeat (3) tick();
    Rst = 1'b1;
    #1;
    chk("rst_mid_active", 32'(Active), 32'(0));
    chk("rst_mid_busy",   32'(Busy),   32'(0));
    bitq.delete();
    tick();
    Rst = 1'b0;
    snap = done_cnt;
    repeat (12) tick();
    chk("rst_no_done", 32'(done_cnt), 32'(snap));
    frame_a5(snap + 1);

    repeat (4) tick();
    chk("bitq_empty", 32'(bitq.size()), 32'(0));
    chk("runq_empty", 32'(runq.size()), 32'(0));
    chk("resq_empty", 32'(resq.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_frame_ctrl.md
Name: crc_frame_ctrl

Overview:
- Frame controller that sits directly upstream and downstream of the serial 8-bit CRC engine.
- Accepts a byte stream over a valid/ready handshake, serializes each byte LSB-first onto the engine's Data/Active inputs, and keeps Active high for the whole frame.
- After the frame ends, it captures the 8 serial CRC bits returned by the engine (CRC bit plus its Valid) into a parallel byte.
- Reports completion, or an error, once per frame.

Parameters:
- WAIT_MAX, 4, max cycles spent in WAIT_CRC without Crc_Valid before a timeout error (1..15).

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous reset, active-high.
- In_Byte  in  8  frame data byte.
- In_Valid  in  1  In_Byte valid.
- In_Last  in  1  In_Byte is the final byte of the frame; qualified by In_Valid.
- In_Ready  out  1  byte accepted on a clock edge where In_Valid && In_Ready (combinational).
- Data  out  1  serial bit to the CRC engine (registered).
- Active  out  1  frame-active strobe to the CRC engine (registered).
- Crc_Bit  in  1  serial CRC bit from the engine.
- Crc_Valid  in  1  Crc_Bit valid.
- Crc_Byte  out  8  collected CRC, bit i = i-th received bit; held until the next Crc_Done.
- Crc_Done  out  1  one-cycle pulse: frame finished, Crc_Byte/Crc_Err valid.
- Crc_Err  out  1  qualifies Crc_Done; held with Crc_Byte.
- Busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, Rst=1): state IDLE; Data=0, Active=0, Crc_Byte=0x00, Crc_Done=0, Crc_Err=0; bit/wait counters, shift register, last flag and underrun flag all cleared.
- States: IDLE, SHIFT, WAIT_CRC, COLLECT.
- In_Ready = (IDLE) || (SHIFT && bit_cnt==7 && !last_q). Never high in WAIT_CRC or COLLECT.
- IDLE: on In_Valid, load sr<=In_Byte, last_q<=In_Last, bit_cnt<=0, Data<=In_Byte[0], Active<=1, go to SHIFT. First serial bit appears 1 cycle after acceptance.
- SHIFT, bit_cnt<7: Data<=sr[bit_cnt+1], bit_cnt++.
- SHIFT, bit_cnt==7:
  - If !last_q and In_Valid: reload as in IDLE. Gapless: Active stays 1, no bubble between bytes.
  - If last_q: Active<=0, Data<=0, go to WAIT_CRC.
  - If !last_q and !In_Valid (underrun): Active<=0, Data<=0, set underrun flag, go to WAIT_CRC. The frame is terminated early; the engine still returns a CRC.
- Frame of N bytes therefore holds Active high for exactly 8N consecutive cycles.
- WAIT_CRC: wait_cnt counts cycles.
  - If Crc_Valid: Crc_Byte shift register bit0<=Crc_Bit, col_cnt<=1, go to COLLECT.
  - If wait_cnt reaches WAIT_MAX with no Crc_Valid: Crc_Byte<=0x00, Crc_Err<=1, Crc_Done<=1, go to IDLE.
- COLLECT:
  - Each cycle with Crc_Valid: capture Crc_Bit into position col_cnt, col_cnt++.
  - On capturing the 8th bit: Crc_Byte<=collected, Crc_Err<=underrun flag, Crc_Done<=1, clear underrun, go to IDLE.
  - If Crc_Valid drops before 8 bits: Crc_Byte<=0x00, Crc_Err<=1, Crc_Done<=1, go to IDLE.
- Crc_Done is high for exactly one cycle per frame. Crc_Byte and Crc_Err hold until the next Crc_Done.
- Crc_Valid/Crc_Bit are ignored in IDLE and SHIFT.
- A new frame may be accepted in the cycle Crc_Done is high (state is already IDLE).
- Reset mid-frame: all state cleared immediately. Active drops asynchronously; no Crc_Done is produced for the aborted frame.
- In_Last on a byte that is never accepted has no effect.

Test Plan:
- Single byte 0xA5 with In_Last=1 -> Active high for 8 cycles, Data=1,0,1,0,0,1,0,1. Engine model returns bits of 0x3C starting 2 cycles after Active falls -> Crc_Byte=0x3C, Crc_Err=0, one-cycle Crc_Done, Busy low after.
- Two bytes 0x01,0x80 back-to-back, In_Valid held -> In_Ready pulses at the bit-7 cycle, Active high for 16 consecutive cycles, Data=1,0×14,1.
- First byte 0xFF without In_Last, In_Valid low at the bit-7 cycle -> Active drops after 8 cycles; model returns 0x5A -> Crc_Byte=0x5A, Crc_Err=1, Crc_Done pulse.
- Frame ends, Crc_Valid never asserted -> after WAIT_MAX=4 cycles Crc_Done=1, Crc_Err=1, Crc_Byte=0x00, state IDLE.
- Crc_Valid high for 5 cycles then low -> Crc_Done=1, Crc_Err=1, Crc_Byte=0x00.
- Rst asserted at bit 3 of the second byte -> Active=0 immediately, Busy=0, no Crc_Done; next frame 0xA5 behaves as in the first scenario.
